pri_dec_seq: RTL and testbench
==============================

// Module: pri_dec_seq
// PURPOSE
//  Sequential decoder: the consuming end of the pri_enc (q,v) code stream.
//  Accepts encoded index q qualified by v, buffers codes in a small FIFO, and
//  replays each one as a one-hot word d, held for HOLD cycles and followed by
//  a 1-cycle idle gap. The producer has no backpressure, so overflow drops the
//  code and raises a sticky flag. Sits downstream of pri_enc in the same domain.
// PARAMETERS
//  N_OUT  4  one-hot output width; valid indices 0..N_OUT-1
//  IDX_W  2  width of q; N_OUT <= 2**IDX_W
//  HOLD   2  cycles each one-hot word is driven (>=1)
//  DEPTH  2  FIFO entries (>=1)
// PORTS
//  Clock    in   1      rising-edge clock
//  Reset_n  in   1      async active-low reset
//  q        in   IDX_W  encoded index from encoder
//  v        in   1      q valid; sampled every rising edge
//  clr      in   1      sync flush: empties FIFO, returns FSM to IDLE, clears flags
//  d        out  N_OUT  one-hot decoded word; all-zero when not driving
//  d_vld    out  1      high while d is driven
//  busy     out  1      FSM not IDLE or FIFO non-empty
//  ovf      out  1      sticky: a valid code was dropped because the FIFO was full
//  err      out  1      sticky: a code with q >= N_OUT was received (dropped)
// BEHAVIOUR
//  Reset (async, Reset_n=0): d=0, d_vld=0, busy=0, ovf=0, err=0; FIFO empty; FSM IDLE.
//  Push: at edge where v=1 and q<N_OUT, q written to FIFO tail if space.
//   - FIFO full and no pop in same edge -> code dropped, ovf<=1.
//   - Full with simultaneous pop -> push accepted (slot freed same edge).
//   - q>=N_OUT -> not written, err<=1 (regardless of fullness).
//   - v=0 -> nothing happens; q ignored.
//  FSM states: IDLE, DRIVE, GAP.
//   - IDLE: FIFO non-empty -> pop head, load d=1<<head, d_vld=1, hold cnt=HOLD-1, go DRIVE.
//   - DRIVE: hold cnt decrements each cycle; at 0 -> d=0, d_vld=0, go GAP.
//   - GAP: one cycle, d=0; then -> IDLE. FIFO non-empty -> pop immediately, go DRIVE
//     (GAP->DRIVE direct; no extra IDLE cycle).
//  Latency: code sampled at edge N (FIFO empty, FSM IDLE) -> d valid after edge N+1.
//   Back-to-back codes: one d word every HOLD+1 cycles.
//  Output d is registered; exactly one bit set when d_vld=1, zero otherwise.
//  FIFO pointers: wrap modulo DEPTH; occupancy count 0..DEPTH, no aliasing at full.
//  clr=1 at an edge: FIFO emptied, FSM->IDLE, d=0, d_vld=0, ovf=0, err=0;
//   a push presented in the same edge is discarded (clr has priority).
//  Reset mid-DRIVE: outputs drop to 0 asynchronously; no partial word after release.
//  busy = (state!=IDLE) | (count!=0).
// TESTING
//  1. Reset_n=0 then release, v=0 -> d=0000, d_vld=0, busy=0, ovf=0, err=0.
//  2. q=2,v=1 one cycle -> d=0100 d_vld=1 after next edge, for exactly 2 cycles; then 1 gap cycle.
//  3. q=0,1,3 on 3 consecutive edges (DEPTH=2) -> d=0001,0010,1000 sequence, each held 2 cycles,
//     1-cycle gaps, ovf=0 (pop frees slot in time); 4 consecutive codes -> 4th dropped, ovf=1.
//  4. N_OUT=3: q=3,v=1 -> no d activity, err=1; following q=1 -> d=010 normally.
//  5. clr asserted during DRIVE with 2 codes queued -> d=0, d_vld=0, busy=0, ovf/err cleared next edge.
//  6. Reset_n pulsed low mid-DRIVE -> d=0, d_vld=0 immediately; FIFO empty after release.

Source files
------------

// File: rtl/pri_dec_seq_if.sv
// Code-stream bundle between a pri_enc producer and the pri_dec_seq consumer.
// The master side drives q/v/clr; the slave side returns the decoded word and status.
interface pri_dec_seq_if #(
    parameter int N_OUT = 4,
    parameter int IDX_W = 2
);
    logic [IDX_W-1:0] q;
    logic             v;
    logic             clr;
    logic [N_OUT-1:0] d;
    logic             d_vld;
    logic             busy;
    logic             ovf;
    logic             err;

    modport master (output q, v, clr, input d, d_vld, busy, ovf, err);
    modport slave  (input q, v, clr, output d, d_vld, busy, ovf, err);
endinterface

// File: rtl/pri_dec_seq.sv
// Sequential decoder: buffers (q,v) codes in a small FIFO and replays each one
// as a registered one-hot word, held for HOLD cycles and followed by one idle cycle.
//
//  state | meaning
//  IDLE  | nothing driven, waiting for a buffered code
//  DRIVE | one-hot word on d, hold counter running down
//  GAP   | single idle cycle; may pop the next code directly
module pri_dec_seq #(
    parameter int N_OUT = 4,
    parameter int IDX_W = 2,
    parameter int HOLD  = 2,
    parameter int DEPTH = 2
) (
    input logic          clk,
    input logic          rst_n,
    pri_dec_seq_if.slave bus
);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int HCNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [IDX_W:0]   N_OUT_L = (IDX_W + 1)'(N_OUT);
    localparam logic [CNT_W-1:0] FULL_L  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_L  = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

    state_t              state, state_n;
    logic [HCNT_W-1:0]   hcnt, hcnt_n;
    logic [N_OUT-1:0]    d_q, d_n;
    logic                vld_q, vld_n;
    logic                ovf_q, err_q;

    logic [IDX_W-1:0]    mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count;

    logic                q_ok, full, pop, push;

    assign q_ok = ({1'b0, bus.q} < N_OUT_L);
    assign full = (count == FULL_L);
    // A pop in the same edge frees a slot, so a full FIFO can still accept.
    assign push = bus.v && q_ok && (!full || pop);

    always_comb begin
        state_n = state;
        hcnt_n  = hcnt;
        d_n     = d_q;
        vld_n   = vld_q;
        pop     = 1'b0;
        case (state)
            IDLE, GAP: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    state_n = DRIVE;
                    d_n     = N_OUT'(1) << mem[rd_ptr];
                    vld_n   = 1'b1;
                    hcnt_n  = HCNT_W'(HOLD - 1);
                end else begin
                    state_n = IDLE;
                    d_n     = '0;
                    vld_n   = 1'b0;
                end
            end
            DRIVE: begin
                if (hcnt == '0) begin
                    state_n = GAP;
                    d_n     = '0;
                    vld_n   = 1'b0;
                end else begin
                    hcnt_n = hcnt - 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                d_n     = '0;
                vld_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            hcnt   <= '0;
            d_q    <= '0;
            vld_q  <= 1'b0;
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.clr) begin
            state  <= IDLE;
            hcnt   <= '0;
            d_q    <= '0;
            vld_q  <= 1'b0;
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_n;
            hcnt  <= hcnt_n;
            d_q   <= d_n;
            vld_q <= vld_n;
            if (bus.v && !q_ok)
                err_q <= 1'b1;
            if (bus.v && q_ok && full && !pop)
                ovf_q <= 1'b1;
            if (push)
                wr_ptr <= (wr_ptr == LAST_L) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == LAST_L) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push && !bus.clr)
            mem[wr_ptr] <= bus.q;
    end

    assign bus.d     = d_q;
    assign bus.d_vld = vld_q;
    assign bus.busy  = (state != IDLE) || (count != '0);
    assign bus.ovf   = ovf_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_pri_dec_seq.sv
// Drives two decoders (N_OUT=4 and N_OUT=3) with the same code stream and checks
// them every cycle against a schedule-based model, plus directed literal checks.
module tb_pri_dec_seq;
    localparam int HOLD  = 2;
    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] q = '0;
    logic       v = 1'b0;
    logic       clr = 1'b0;

    int errors = 0;
    int checks = 0;

    pri_dec_seq_if #(.N_OUT(4), .IDX_W(2)) if4 ();
    pri_dec_seq_if #(.N_OUT(3), .IDX_W(2)) if3 ();

    assign if4.q = q;
    assign if4.v = v;
    assign if4.clr = clr;
    assign if3.q = q;
    assign if3.v = v;
    assign if3.clr = clr;

    pri_dec_seq #(.N_OUT(4), .IDX_W(2), .HOLD(HOLD), .DEPTH(DEPTH)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    pri_dec_seq #(.N_OUT(3), .IDX_W(2), .HOLD(HOLD), .DEPTH(DEPTH)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    always #5 clk = ~clk;

    // Model: a plain list of pending codes and the edge at which each word was started.
    int ecnt = 0;
    int msize[2];
    int mbuf[2][16];
    int next_pop[2];
    int last_pop[2];
    int cur[2];
    bit movf[2];
    bit merr[2];
    int nout[2] = '{4, 3};

    function automatic void model_clear(int i);
        msize[i]    = 0;
        next_pop[i] = 0;
        last_pop[i] = -100;
        cur[i]      = 0;
        movf[i]     = 1'b0;
        merr[i]     = 1'b0;
    endfunction

    function automatic void model_step(int i, bit vv, int qq);
        if (msize[i] > 0 && ecnt >= next_pop[i]) begin
            cur[i] = mbuf[i][0];
            for (int k = 0; k < 15; k++) mbuf[i][k] = mbuf[i][k+1];
            msize[i]--;
            last_pop[i] = ecnt;
            next_pop[i] = ecnt + HOLD + 1;
        end
        if (vv) begin
            if (qq >= nout[i]) merr[i] = 1'b1;
            else if (msize[i] < DEPTH) begin
                mbuf[i][msize[i]] = qq;
                msize[i]++;
            end else movf[i] = 1'b1;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_clear(0);
            model_clear(1);
        end else begin
            ecnt++;
            for (int i = 0; i < 2; i++) begin
                if (clr) model_clear(i);
                else model_step(i, v, int'(q));
            end
        end
    end

    function automatic int exp_vld(int i);
        return (ecnt >= last_pop[i] && ecnt <= last_pop[i] + HOLD - 1) ? 1 : 0;
    endfunction

    function automatic int exp_d(int i);
        return (exp_vld(i) != 0) ? (1 << cur[i]) : 0;
    endfunction

    function automatic int exp_busy(int i);
        return (ecnt < next_pop[i] || msize[i] > 0) ? 1 : 0;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("m4.d",     int'(if4.d),     exp_d(0));
        check("m4.d_vld", int'(if4.d_vld), exp_vld(0));
        check("m4.busy",  int'(if4.busy),  exp_busy(0));
        check("m4.ovf",   int'(if4.ovf),   int'(movf[0]));
        check("m4.err",   int'(if4.err),   int'(merr[0]));
        check("m3.d",     int'(if3.d),     exp_d(1));
        check("m3.d_vld", int'(if3.d_vld), exp_vld(1));
        check("m3.busy",  int'(if3.busy),  exp_busy(1));
        check("m3.ovf",   int'(if3.ovf),   int'(movf[1]));
        check("m3.err",   int'(if3.err),   int'(merr[1]));
    end

    task automatic step(input bit vv, input int qq, input bit cc);
        v   = vv;
        q   = 2'(qq);
        clr = cc;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0, 1'b0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        check("rst.d",    int'(if4.d),     0);
        check("rst.vld",  int'(if4.d_vld), 0);
        check("rst.busy", int'(if4.busy),  0);
        check("rst.flag", int'({if4.ovf, if4.err}), 0);

        // single code
        step(1'b1, 2, 1'b0);
        check("one.busy", int'(if4.busy), 1);
        check("one.d0",   int'(if4.d),    0);
        idle(1);
        check("one.d1",   int'(if4.d),    4'b0100);
        check("one.vld",  int'(if4.d_vld), 1);
        idle(1);
        check("one.d2",   int'(if4.d),    4'b0100);
        idle(1);
        check("one.gap",  int'(if4.d),    0);
        idle(3);

        // three back-to-back codes fit; fourth of a burst overflows
        step(1'b1, 0, 1'b0);
        step(1'b1, 1, 1'b0);
        check("b3.d0", int'(if4.d), 4'b0001);
        step(1'b1, 3, 1'b0);
        idle(2);
        check("b3.d1", int'(if4.d), 4'b0010);
        idle(3);
        check("b3.d3", int'(if4.d), 4'b1000);
        check("b3.ovf", int'(if4.ovf), 0);
        idle(6);
        step(1'b1, 0, 1'b0);
        step(1'b1, 1, 1'b0);
        step(1'b1, 2, 1'b0);
        step(1'b1, 3, 1'b0);
        check("b4.ovf", int'(if4.ovf), 1);
        idle(12);

        // out-of-range code on the 3-wide decoder
        step(1'b0, 0, 1'b1);
        step(1'b1, 3, 1'b0);
        step(1'b1, 1, 1'b0);
        check("err.e3", int'(if3.err), 1);
        check("err.e4", int'(if4.err), 0);
        idle(1);
        check("err.d3", int'(if3.d), 3'b010);
        idle(6);

        // flush during DRIVE with two queued
        step(1'b1, 0, 1'b0);
        step(1'b1, 1, 1'b0);
        step(1'b1, 2, 1'b0);
        check("clr.pre", int'(if4.d_vld), 1);
        step(1'b0, 0, 1'b1);
        check("clr.d",    int'(if4.d),     0);
        check("clr.vld",  int'(if4.d_vld), 0);
        check("clr.busy", int'(if4.busy),  0);
        check("clr.flag", int'({if3.ovf, if3.err}), 0);
        idle(4);

        // async reset mid-DRIVE
        step(1'b1, 1, 1'b0);
        step(1'b1, 3, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("ar.d",   int'(if4.d),     0);
        check("ar.vld", int'(if4.d_vld), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);
        check("ar.busy", int'(if4.busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
